// File: rtl/instruction_execute_pkg.sv
// Shared definitions for the execute stage.
//   - datapath widths (DATA_W, PC_W, REG_W)
//   - alu_op encodings coming from the ID/EX register
//   - R-type funct codes
//   - internal ALU operation enum
//   - EX/MEM register layout (control + data)
package instruction_execute_pkg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 10;
    localparam int REG_W  = 5;

    // alu_op encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // funct codes (sign_ext[5:0] of an R-type)
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        FN_ADD,
        FN_SUB,
        FN_AND,
        FN_OR,
        FN_NOR,
        FN_SLT,
        FN_ZERO
    } aluFn_t;

    typedef struct packed {
        logic branch;
        logic memRead;
        logic memWrite;
        logic memToReg;
        logic regWrite;
    } exMemCtrl_t;

    typedef struct packed {
        exMemCtrl_t         ctrl;
        logic [DATA_W-1:0]  aluResult;
        logic               zero;
        logic [DATA_W-1:0]  storeData;
        logic [REG_W-1:0]   writeReg;
        logic [PC_W-1:0]    branchTarget;
    } exMem_t;

endpackage

// File: rtl/instruction_execute_if.sv
// Bus between the pipeline and the execute stage.
//   ID/EX side : control bits, operands, register numbers, flush
//   MEM/WB side: write-back forwarding source
//   EX/MEM side: registered control and data results
// master = pipeline/testbench driving the stage, slave = execute stage.
interface instruction_execute_if;
    import instruction_execute_pkg::*;

    logic              flush;
    // ID/EX control
    logic [1:0]        aluOp;
    logic              regDst;
    logic              aluSrc;
    logic              branch;
    logic              memRead;
    logic              memWrite;
    logic              memToReg;
    logic              regWrite;
    // ID/EX data
    logic [DATA_W-1:0] regA;
    logic [DATA_W-1:0] regB;
    logic [DATA_W-1:0] signExt;
    logic [PC_W-1:0]   pcCount;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    // MEM/WB forwarding
    logic              wbRegWrite;
    logic [REG_W-1:0]  wbReg;
    logic [DATA_W-1:0] wbData;
    // EX/MEM outputs
    logic              branchOut;
    logic              memReadOut;
    logic              memWriteOut;
    logic              memToRegOut;
    logic              regWriteOut;
    logic [DATA_W-1:0] aluResult;
    logic              zero;
    logic [DATA_W-1:0] storeData;
    logic [REG_W-1:0]  writeReg;
    logic [PC_W-1:0]   branchTarget;

    modport master (
        output flush, aluOp, regDst, aluSrc, branch, memRead, memWrite, memToReg, regWrite,
        output regA, regB, signExt, pcCount, rs, rt, rd,
        output wbRegWrite, wbReg, wbData,
        input  branchOut, memReadOut, memWriteOut, memToRegOut, regWriteOut,
        input  aluResult, zero, storeData, writeReg, branchTarget
    );

    modport slave (
        input  flush, aluOp, regDst, aluSrc, branch, memRead, memWrite, memToReg, regWrite,
        input  regA, regB, signExt, pcCount, rs, rt, rd,
        input  wbRegWrite, wbReg, wbData,
        output branchOut, memReadOut, memWriteOut, memToRegOut, regWriteOut,
        output aluResult, zero, storeData, writeReg, branchTarget
    );

endinterface

// File: rtl/instruction_execute_alu_core.sv
// Combinational ALU with alu_op / funct decode.
//   aluOp  : 00 add, 01 sub, 10 use funct, 11 reserved (result 0)
//   funct  : R-type function field
//   opA/opB: operands
//   result : wraps modulo 2^DATA_W; slt is a signed compare giving 1/0
module alu_core
    import instruction_execute_pkg::*;
(
    input  logic [1:0]        aluOp,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] opA,
    input  logic [DATA_W-1:0] opB,
    output logic [DATA_W-1:0] result
);

    aluFn_t fn;

    always_comb begin
        fn = FN_ZERO;
        unique case (aluOp)
            ALUOP_ADD:   fn = FN_ADD;
            ALUOP_SUB:   fn = FN_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: fn = FN_ADD;
                    FUNCT_SUB: fn = FN_SUB;
                    FUNCT_AND: fn = FN_AND;
                    FUNCT_OR:  fn = FN_OR;
                    FUNCT_NOR: fn = FN_NOR;
                    FUNCT_SLT: fn = FN_SLT;
                    default:   fn = FN_ZERO;
                endcase
            end
            ALUOP_RSVD:  fn = FN_ZERO;
            default:     fn = FN_ZERO;
        endcase
    end

    always_comb begin
        result = '0;
        case (fn)
            FN_ADD:  result = opA + opB;
            FN_SUB:  result = opA - opB;
            FN_AND:  result = opA & opB;
            FN_OR:   result = opA | opB;
            FN_NOR:  result = ~(opA | opB);
            FN_SLT:  result = ($signed(opA) < $signed(opB)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instruction_execute.sv
// Execute stage: operand forwarding, ALU, branch target and EX/MEM register.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears the whole EX/MEM register
//   bus   : ID/EX inputs, MEM/WB forwarding inputs, flush, EX/MEM outputs
// Everything is computed combinationally from the current inputs and captured
// on the next edge. flush squashes only the control bits.
module instruction_execute
    import instruction_execute_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    instruction_execute_if.slave  bus
);

    exMem_t            exMem;
    exMem_t            exMemNext;
    logic [DATA_W-1:0] fwdA;
    logic [DATA_W-1:0] fwdB;
    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] aluOut;

    // Forwarding: the own EX/MEM result is newer than MEM/WB, so it wins.
    // Register 0 is hard-wired zero and is never forwarded.
    always_comb begin
        fwdA = bus.regA;
        if (exMem.ctrl.regWrite && exMem.writeReg != '0 && exMem.writeReg == bus.rs)
            fwdA = exMem.aluResult;
        else if (bus.wbRegWrite && bus.wbReg != '0 && bus.wbReg == bus.rs)
            fwdA = bus.wbData;
    end

    always_comb begin
        fwdB = bus.regB;
        if (exMem.ctrl.regWrite && exMem.writeReg != '0 && exMem.writeReg == bus.rt)
            fwdB = exMem.aluResult;
        else if (bus.wbRegWrite && bus.wbReg != '0 && bus.wbReg == bus.rt)
            fwdB = bus.wbData;
    end

    assign aluB = bus.aluSrc ? bus.signExt : fwdB;

    alu_core u_alu (
        .aluOp  (bus.aluOp),
        .funct  (bus.signExt[5:0]),
        .opA    (fwdA),
        .opB    (aluB),
        .result (aluOut)
    );

    always_comb begin
        exMemNext               = '0;
        exMemNext.ctrl.branch   = bus.branch;
        exMemNext.ctrl.memRead  = bus.memRead;
        exMemNext.ctrl.memWrite = bus.memWrite;
        exMemNext.ctrl.memToReg = bus.memToReg;
        exMemNext.ctrl.regWrite = bus.regWrite;
        if (bus.flush)
            exMemNext.ctrl = '0;
        exMemNext.aluResult    = aluOut;
        exMemNext.zero         = (aluOut == '0);
        exMemNext.storeData    = fwdB;
        exMemNext.writeReg     = bus.regDst ? bus.rd : bus.rt;
        exMemNext.branchTarget = bus.pcCount + bus.signExt[PC_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            exMem <= '0;
        else
            exMem <= exMemNext;
    end

    assign bus.branchOut    = exMem.ctrl.branch;
    assign bus.memReadOut   = exMem.ctrl.memRead;
    assign bus.memWriteOut  = exMem.ctrl.memWrite;
    assign bus.memToRegOut  = exMem.ctrl.memToReg;
    assign bus.regWriteOut  = exMem.ctrl.regWrite;
    assign bus.aluResult    = exMem.aluResult;
    assign bus.zero         = exMem.zero;
    assign bus.storeData    = exMem.storeData;
    assign bus.writeReg     = exMem.writeReg;
    assign bus.branchTarget = exMem.branchTarget;

endmodule

// File: tb/tb_instruction_execute.sv
module tb_instruction_execute;

    logic clk;
    logic reset;
    int   passCnt;
    int   totalCnt;

    instruction_execute_if bus ();

    instruction_execute dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clearInputs();
        bus.flush = 0; bus.aluOp = 2'b00; bus.regDst = 0; bus.aluSrc = 0;
        bus.branch = 0; bus.memRead = 0; bus.memWrite = 0; bus.memToReg = 0; bus.regWrite = 0;
        bus.regA = 0; bus.regB = 0; bus.signExt = 0; bus.pcCount = 0;
        bus.rs = 0; bus.rt = 0; bus.rd = 0;
        bus.wbRegWrite = 0; bus.wbReg = 0; bus.wbData = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clearInputs();
        reset = 1;
        bus.regA = 32'h1234; bus.regWrite = 1; bus.branch = 1; bus.signExt = 32'h5;
        tick(); tick();
        totalCnt++; if (bus.aluResult !== 32'd0) $display("FAIL reset_alu got %h exp 0", bus.aluResult); else passCnt++;
        totalCnt++; if (bus.zero !== 1'b0) $display("FAIL reset_zero got %b exp 0", bus.zero); else passCnt++;
        totalCnt++; if (bus.branchTarget !== 10'd0) $display("FAIL reset_target got %0d exp 0", bus.branchTarget); else passCnt++;
        totalCnt++; if ({bus.branchOut, bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.regWriteOut} !== 5'b0)
            $display("FAIL reset_ctrl got %b exp 00000", {bus.branchOut, bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.regWriteOut});
        else passCnt++;
        reset = 0;
    endtask

    // R-type add, then a dependent sub using the EX/MEM forward
    task automatic test_back_to_back();
        clearInputs();
        bus.regA = 5; bus.regB = 7; bus.aluOp = 2'b10; bus.signExt = 32'h20;
        bus.regDst = 1; bus.rd = 3; bus.rs = 1; bus.rt = 2; bus.regWrite = 1;
        tick();
        totalCnt++; if (bus.aluResult !== 32'd12) $display("FAIL add_result got %0d exp 12", bus.aluResult); else passCnt++;
        totalCnt++; if (bus.writeReg !== 5'd3) $display("FAIL add_wreg got %0d exp 3", bus.writeReg); else passCnt++;
        totalCnt++; if (bus.zero !== 1'b0) $display("FAIL add_zero got %b exp 0", bus.zero); else passCnt++;
        totalCnt++; if (bus.storeData !== 32'd7) $display("FAIL add_store got %0d exp 7", bus.storeData); else passCnt++;
        totalCnt++; if (bus.branchTarget !== 10'd32) $display("FAIL add_target got %0d exp 32", bus.branchTarget); else passCnt++;
        totalCnt++; if (bus.regWriteOut !== 1'b1) $display("FAIL add_rw got %b exp 1", bus.regWriteOut); else passCnt++;
        clearInputs();
        bus.rs = 3; bus.regA = 0; bus.rt = 2; bus.regB = 12; bus.aluOp = 2'b10; bus.signExt = 32'h22;
        tick();
        totalCnt++; if (bus.aluResult !== 32'd0) $display("FAIL b2b_result got %0d exp 0", bus.aluResult); else passCnt++;
        totalCnt++; if (bus.zero !== 1'b1) $display("FAIL b2b_zero got %b exp 1", bus.zero); else passCnt++;
    endtask

    task automatic test_double_hazard();
        clearInputs();
        bus.regA = 32'h10; bus.rs = 5; bus.rt = 6; bus.regDst = 1; bus.rd = 4; bus.regWrite = 1;
        tick();
        totalCnt++; if (bus.aluResult !== 32'h10) $display("FAIL dh_setup got %h exp 10", bus.aluResult); else passCnt++;
        clearInputs();
        bus.rs = 4; bus.regA = 0; bus.rt = 6; bus.regB = 1;
        bus.wbRegWrite = 1; bus.wbReg = 4; bus.wbData = 32'h20;
        tick();
        totalCnt++; if (bus.aluResult !== 32'h11) $display("FAIL dh_result got %h exp 11", bus.aluResult); else passCnt++;
        // MEM/WB only, on operand B, checked through store_data too
        clearInputs();
        bus.rs = 1; bus.regA = 2; bus.rt = 7; bus.regB = 0;
        bus.wbRegWrite = 1; bus.wbReg = 7; bus.wbData = 32'h30;
        tick();
        totalCnt++; if (bus.aluResult !== 32'h32) $display("FAIL wbB_result got %h exp 32", bus.aluResult); else passCnt++;
        totalCnt++; if (bus.storeData !== 32'h30) $display("FAIL wbB_store got %h exp 30", bus.storeData); else passCnt++;
        // alu_src selects sign_ext while store_data keeps the forwarded B
        clearInputs();
        bus.rs = 1; bus.regA = 2; bus.rt = 7; bus.regB = 0; bus.aluSrc = 1; bus.signExt = 32'h100;
        bus.wbRegWrite = 1; bus.wbReg = 7; bus.wbData = 32'h30;
        tick();
        totalCnt++; if (bus.aluResult !== 32'h102) $display("FAIL imm_result got %h exp 102", bus.aluResult); else passCnt++;
        totalCnt++; if (bus.storeData !== 32'h30) $display("FAIL imm_store got %h exp 30", bus.storeData); else passCnt++;
    endtask

    task automatic test_reg0_guard();
        clearInputs();
        bus.regA = 32'h55; bus.regDst = 1; bus.rd = 0; bus.regWrite = 1; bus.rs = 8; bus.rt = 9;
        tick();
        clearInputs();
        bus.rs = 0; bus.regA = 0; bus.rt = 0; bus.regB = 0;
        bus.wbRegWrite = 1; bus.wbReg = 0; bus.wbData = 32'hFFFF;
        tick();
        totalCnt++; if (bus.aluResult !== 32'd0) $display("FAIL r0_result got %h exp 0", bus.aluResult); else passCnt++;
        totalCnt++; if (bus.zero !== 1'b1) $display("FAIL r0_zero got %b exp 1", bus.zero); else passCnt++;
    endtask

    task automatic test_branch_flush();
        clearInputs();
        bus.pcCount = 10'd1020; bus.signExt = 32'd8; bus.branch = 1; bus.flush = 1;
        bus.regWrite = 1; bus.memRead = 1; bus.aluSrc = 1; bus.regA = 3; bus.rs = 9; bus.rt = 10;
        tick();
        totalCnt++; if (bus.branchTarget !== 10'd4) $display("FAIL bt_wrap got %0d exp 4", bus.branchTarget); else passCnt++;
        totalCnt++; if (bus.branchOut !== 1'b0) $display("FAIL flush_branch got %b exp 0", bus.branchOut); else passCnt++;
        totalCnt++; if (bus.regWriteOut !== 1'b0) $display("FAIL flush_rw got %b exp 0", bus.regWriteOut); else passCnt++;
        totalCnt++; if (bus.memReadOut !== 1'b0) $display("FAIL flush_mr got %b exp 0", bus.memReadOut); else passCnt++;
        totalCnt++; if (bus.aluResult !== 32'd11) $display("FAIL flush_data got %0d exp 11", bus.aluResult); else passCnt++;
        bus.flush = 0; bus.memWrite = 1; bus.memToReg = 1;
        tick();
        totalCnt++; if ({bus.branchOut, bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.regWriteOut} !== 5'b11111)
            $display("FAIL noflush_ctrl got %b exp 11111", {bus.branchOut, bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.regWriteOut});
        else passCnt++;
        totalCnt++; if (bus.writeReg !== 5'd10) $display("FAIL rt_wreg got %0d exp 10", bus.writeReg); else passCnt++;
    endtask

    task automatic test_logic_ops();
        logic [5:0]  fn  [7] = '{6'h24, 6'h25, 6'h27, 6'h22, 6'h2A, 6'h21, 6'h20};
        logic [31:0] exp [7] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'h000F_F000, 32'hE0FF_F1F0,
                                 32'd1, 32'd0, 32'h00E0_100E};
        for (int i = 0; i < 7; i++) begin
            clearInputs();
            bus.rs = 12; bus.rt = 13; bus.regA = 32'hF0F0_00FF; bus.regB = 32'h0FF0_0F0F;
            bus.aluOp = 2'b10; bus.signExt = {26'd0, fn[i]};
            tick();
            totalCnt++; if (bus.aluResult !== exp[i]) $display("FAIL funct_%h got %h exp %h", fn[i], bus.aluResult, exp[i]); else passCnt++;
        end
        clearInputs();
        bus.rs = 12; bus.rt = 13; bus.regA = 32'h5; bus.regB = 32'h2; bus.aluOp = 2'b11;
        tick();
        totalCnt++; if (bus.aluResult !== 32'd0 || bus.zero !== 1'b1) $display("FAIL rsvd_op got %h/%b exp 0/1", bus.aluResult, bus.zero); else passCnt++;
        bus.aluOp = 2'b01;
        tick();
        totalCnt++; if (bus.aluResult !== 32'd3) $display("FAIL op_sub got %h exp 3", bus.aluResult); else passCnt++;
        // bubble: all-zero controls
        clearInputs();
        bus.regA = 32'h3;
        tick();
        totalCnt++; if (bus.regWriteOut !== 1'b0 || bus.aluResult !== 32'h3) $display("FAIL bubble got %b/%h exp 0/3", bus.regWriteOut, bus.aluResult); else passCnt++;
    endtask

    task automatic test_slt_reset();
        clearInputs();
        bus.regA = 32'hFFFF_FFFF; bus.regB = 1; bus.aluOp = 2'b10; bus.signExt = 32'h2A;
        bus.rs = 14; bus.rt = 15; bus.regDst = 1; bus.rd = 5; bus.regWrite = 1; bus.branch = 1;
        tick();
        totalCnt++; if (bus.aluResult !== 32'd1) $display("FAIL slt_neg got %h exp 1", bus.aluResult); else passCnt++;
        reset = 1; bus.flush = 1;
        tick();
        totalCnt++; if (bus.aluResult !== 0 || bus.zero !== 0 || bus.storeData !== 0 || bus.writeReg !== 0 || bus.branchTarget !== 0)
            $display("FAIL rstflush_data got %h %b %h %0d %0d exp all 0", bus.aluResult, bus.zero, bus.storeData, bus.writeReg, bus.branchTarget);
        else passCnt++;
        totalCnt++; if ({bus.branchOut, bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.regWriteOut} !== 5'b0)
            $display("FAIL rstflush_ctrl got %b exp 00000", {bus.branchOut, bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.regWriteOut});
        else passCnt++;
        reset = 0; bus.flush = 0;
        tick();
        totalCnt++; if (bus.aluResult !== 32'd1 || bus.writeReg !== 5'd5 || bus.regWriteOut !== 1'b1)
            $display("FAIL post_reset got %h %0d %b exp 1 5 1", bus.aluResult, bus.writeReg, bus.regWriteOut);
        else passCnt++;
    endtask

    initial begin
        passCnt = 0;
        totalCnt = 0;
        reset = 1;
        clearInputs();
        test_reset();
        test_back_to_back();
        test_double_hazard();
        test_reg0_guard();
        test_branch_flush();
        test_logic_ops();
        test_slt_reset();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/instruction_execute.md
INSTRUCTION_EXECUTE -- requirements
Module: instruction_execute

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous, active-high.
REQ-002 SHALL have flush in 1: branch-taken squash; zeroes the EX/MEM control bits on the next edge.
REQ-003 SHALL have ID/EX inputs: alu_op 2, reg_dst 1, alu_src 1, branch 1, mem_read 1, mem_write 1, mem_to_reg 1, reg_write 1.
REQ-004 SHALL have ID/EX data inputs: reg_a 32, reg_b 32, sign_ext 32, pc_count 10, rs 5, rt 5, rd 5.
REQ-005 SHALL have MEM/WB forwarding inputs: wb_reg_write 1, wb_reg 5, wb_data 32.
REQ-006 SHALL have registered EX/MEM outputs: branch_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out (1 each).
REQ-007 SHALL have registered EX/MEM data outputs: alu_result 32, zero 1, store_data 32, write_reg 5, branch_target 10.

Function
REQ-008 SHALL compute all results combinationally from the current inputs and capture them on the rising clk edge (1-cycle latency).
REQ-009 Operand A SHALL be reg_a, overridden by forwarding.
REQ-010 Forward source 1: own registered alu_result, when reg_write_out=1, write_reg!=0 and write_reg==rs.
REQ-011 Forward source 2, used only when source 1 does not apply: wb_data, when wb_reg_write=1, wb_reg!=0 and wb_reg==rs.
REQ-012 Operand B pre-mux SHALL follow the same two rules with rt instead of rs; EX/MEM has priority over MEM/WB.
REQ-013 store_data SHALL capture the forwarded operand B pre-mux value.
REQ-014 ALU input B SHALL be sign_ext when alu_src=1, otherwise the forwarded operand B.
REQ-015 alu_op decode: 00 add, 01 sub, 10 decode by funct=sign_ext[5:0], 11 reserved with result 0.
REQ-016 funct decode: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt; any other funct gives result 0.
REQ-017 add/sub SHALL wrap modulo 2^32 with no overflow flag; slt SHALL be a signed compare giving 32'd1 or 32'd0.
REQ-018 zero SHALL register (ALU result == 0).
REQ-019 write_reg SHALL register rd when reg_dst=1, otherwise rt.
REQ-020 branch_target SHALL register pc_count + sign_ext[9:0], wrapping modulo 1024.
REQ-021 When flush=1 at an edge, all five control outputs SHALL register 0; data outputs SHALL register normally.
REQ-022 When reset and flush are both high, reset SHALL take precedence.
REQ-023 An all-zero control input set SHALL pass through as a bubble; no state is held beyond the EX/MEM register.

Reset
REQ-024 When reset=1 at a rising edge, every registered output SHALL become 0 (including zero=0 and branch_target=0).
REQ-025 Reset asserted mid-stream SHALL discard the in-flight result; while reset is held, no forwarding from the own register SHALL occur.
REQ-026 In the first cycle after reset release, outputs SHALL reflect the inputs present at that edge.

Structure
REQ-027 A shared package SHALL hold: alu_op encodings, funct codes, the internal ALU-operation enum, and widths (DATA_W=32, PC_W=10, REG_W=5).
REQ-028 Sub-module alu_core SHALL contain the alu_op/funct decode and the combinational ALU.
REQ-029 Forwarding muxes and the EX/MEM register SHALL remain in instruction_execute.

Verification
REQ-030 R-type add: reg_a=5, reg_b=7, alu_op=10, funct=100000, reg_dst=1, rd=3, no forwarding -> next edge alu_result=12, write_reg=3, zero=0.
REQ-031 Back-to-back dependency:
- Cycle 1: writes r3=12.
- Cycle 2: sub with rs=3, reg_a=0 (stale), reg_b=12, funct=100010.
- Required: alu_result=0, zero=1 (EX/MEM forward used).
REQ-032 Double hazard: rs=4, EX/MEM write_reg=4 with 0x10, wb_reg=4 with wb_data=0x20, add with reg_b=1 -> alu_result=0x11.
REQ-033 Register 0 guard: wb_reg=0, wb_reg_write=1, wb_data=0xFFFF, rs=0, reg_a=0 -> operand A stays 0.
REQ-034 beq flush:
- Inputs: pc_count=1020, sign_ext=8, branch=1, flush=1.
- Required: branch_target=4 (wrap), branch_out=0, reg_write_out=0.
REQ-035 slt with reg_a=0xFFFFFFFF, reg_b=1 -> alu_result=1; then reset=1 with flush=1 -> all outputs 0.
